x_mod_m_seq: RTL and testbench

X_MOD_M_SEQ -- requirements
Module: x_mod_m_seq

---
 rtl/xmod_pkg.sv | 26 ++
 rtl/x_mod_m_fold.sv | 27 ++
 rtl/x_mod_m_seq.sv | 119 +++++++++++
 tb/tb_x_mod_m_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xmod_pkg.sv
// Shared helpers for the sequential X mod M reducer: ceil-log2, 2^e mod m, FSM states.
package xmod_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, FOLD, CORR, DONE} xmod_state_e;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Doubling keeps every intermediate below 2*m, so int never overflows.
  function automatic int pow2mod(input int e, input int m);
    int r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * 2) % m;
    return r;
  endfunction

endpackage

// File: rtl/x_mod_m_fold.sv
// Combinational fold (lo + hi*W1) and single conditional subtraction of M.
module x_mod_m_fold #(
  parameter int K  = 7,
  parameter int AW = 18,
  parameter int M  = 107,
  parameter int W1 = 21
) (
  input  logic [AW-1:0] acc,
  output logic [AW-1:0] fold_val,
  output logic [AW-1:0] corr_val,
  output logic          hi_zero
);

  localparam logic [K-1:0] W1_V = K'(W1);

  logic [AW-K-1:0] hi;
  logic [K-1:0]    lo;

  assign hi = acc[AW-1:K];
  assign lo = acc[K-1:0];

  // W1 <= M-1 < 2^K - 1, so lo + hi*W1 stays below 2^AW.
  assign fold_val = AW'(lo) + AW'(hi) * AW'(W1_V);
  assign corr_val = (acc >= AW'(M)) ? acc - AW'(M) : acc;
  assign hi_zero  = (hi == '0);

endmodule

// File: rtl/x_mod_m_seq.sv
// Sequential X mod M: weighted chunk accumulate, iterative fold, final correction.
// Optional abort input enabled by defining XMOD_ABORT_EN.
module x_mod_m_seq
  import xmod_pkg::*;
#(
  parameter int XW = 100,
  parameter int M  = 107,
  localparam int K   = clog2(M),
  localparam int NCH = (XW + K - 1) / K,
  localparam int W1  = pow2mod(K, M),
  localparam int AW  = 2 * K + clog2(NCH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] X,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef XMOD_ABORT_EN
  input  logic          abort,
`endif
  output logic [K-1:0]  R
);

  localparam int IW = clog2(NCH + 1);

  xmod_state_e         state, state_n;
  logic [NCH*K-1:0]    x_q;
  logic [AW-1:0]       acc;
  logic [IW-1:0]       idx;
  logic [K-1:0]        r_q;
  logic [K-1:0]        wt_tab [NCH];
  logic [K-1:0]        wt_sel;
  logic [AW-1:0]       term;
  logic [AW-1:0]       fold_val, corr_val;
  logic                hi_zero;
  logic                abort_hit;

  // Chunk weights 2^(i*K) mod M are fixed at elaboration.
  for (genvar g = 0; g < NCH; g++) begin : g_wt
    assign wt_tab[g] = K'(pow2mod(g * K, M));
  end

  always_comb begin
    wt_sel = '0;
    for (int i = 0; i < NCH; i++)
      if (idx == IW'(i)) wt_sel = wt_tab[i];
  end

  assign term = AW'(x_q[K-1:0]) * AW'(wt_sel);

`ifdef XMOD_ABORT_EN
  assign abort_hit = abort && (state inside {ACCUM, FOLD, CORR});
`else
  assign abort_hit = 1'b0;
`endif

  x_mod_m_fold #(.K(K), .AW(AW), .M(M), .W1(W1)) u_fold (
    .acc      (acc),
    .fold_val (fold_val),
    .corr_val (corr_val),
    .hi_zero  (hi_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = ACCUM;
      ACCUM:   if (idx == IW'(NCH - 1)) state_n = FOLD;
      FOLD:    if (hi_zero) state_n = CORR;
      CORR:    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
      r_q <= '0;
    end else if (!abort_hit) begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= '0;
          idx <= '0;
        end
        ACCUM: begin
          acc <= acc + term;
          idx <= idx + 1'b1;
        end
        FOLD: if (!hi_zero) acc <= fold_val;
        CORR: begin
          acc <= corr_val;
          r_q <= corr_val[K-1:0];
        end
        default: ;
      endcase
    end
  end

  // Operand shift register: chunk i sits in the low K bits during ACCUM cycle i.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) x_q <= (NCH*K)'(X);
    else if (state == ACCUM)       x_q <= x_q >> K;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign R         = r_q;

endmodule

// File: tb/tb_x_mod_m_seq.sv
// Self-checking bench for x_mod_m_seq (default XW=100, M=107); abort case under XMOD_ABORT_EN.
module tb_x_mod_m_seq;

  localparam int XW  = 100;
  localparam int M   = 107;
  localparam int K   = 7;
  localparam int NCH = 15;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] X;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  R;
`ifdef XMOD_ABORT_EN
  logic          abort;
`endif

  int n_tests;
  int n_fail;
  logic [K-1:0] sb[$];

  typedef struct {
    logic [XW-1:0] x;
    logic [K-1:0]  r;
    int            lat;
  } vec_t;

  vec_t vecs[8];

  x_mod_m_seq #(.XW(XW), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef XMOD_ABORT_EN
    .abort     (abort),
`endif
    .R         (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: MSB-first bit-serial remainder.
  function automatic logic [K-1:0] gold(input logic [XW-1:0] x);
    int r;
    r = 0;
    for (int i = XW - 1; i >= 0; i--) r = (r * 2 + int'(x[i])) % M;
    return K'(r);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Latency is the index of the first edge after the accept edge at which out_valid is seen high.
  task automatic wait_valid(output bit seen, output int lat);
    int cnt;
    seen = 1'b0;
    cnt  = 0;
    while (cnt < 200) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cnt++;
    end
    lat = cnt + 1;
    if (!seen) chk("out_valid_timeout", 128'(0), 128'(1));
  endtask

  task automatic do_op(input logic [XW-1:0] x, input logic [K-1:0] exp_r,
                       input int exp_lat, input string nm);
    bit seen;
    int lat;
    int f;
    logic [K-1:0] e;
    @(negedge clk);
    chk({nm, "_in_ready"}, 128'(in_ready), 128'(1));
    X         = x;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    sb.push_back(exp_r);
    @(negedge clk);
    in_valid = 1'b0;
    X        = XW'({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_valid(seen, lat);
    if (seen) begin
      if (sb.size() == 0) chk({nm, "_sb_empty"}, 128'(0), 128'(1));
      else begin
        e = sb.pop_front();
        chk({nm, "_R"}, 128'(R), 128'(e));
      end
      if (exp_lat >= 0) chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
      f = lat - NCH - 2;
      chk({nm, "_fold_cycles_1_to_10"}, 128'(f >= 1 && f <= 10), 128'(1));
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, 128'(out_valid), 128'(0));
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    bit seen;
    int lat;
    logic [XW-1:0] xr;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X         = '0;
`ifdef XMOD_ABORT_EN
    abort     = 1'b0;
`endif

    vecs[0] = '{x: XW'(0),    r: 7'd0,   lat: 18};
    vecs[1] = '{x: XW'(107),  r: 7'd0,   lat: -1};
    vecs[2] = '{x: XW'(1000), r: 7'd37,  lat: -1};
    vecs[3] = '{x: XW'(106),  r: 7'd106, lat: -1};
    vecs[4] = '{x: {XW{1'b1}}, r: 7'd101, lat: -1};
    vecs[5] = '{x: XW'(1),    r: 7'd1,   lat: -1};
    vecs[6] = '{x: XW'(128),  r: 7'd21,  lat: -1};
    vecs[7] = '{x: XW'(214),  r: 7'd0,   lat: -1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_R", 128'(R), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    for (int i = 0; i < 8; i++) do_op(vecs[i].x, vecs[i].r, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 1500; i++) begin
      xr = XW'({$urandom(), $urandom(), $urandom(), $urandom()});
      if (i % 4 == 0) xr[XW-1:XW-20] = '1;
      do_op(xr, gold(xr), -1, "rand");
    end

    // Backpressure with ignored in_valid pulses while busy
    @(negedge clk);
    X = XW'(1000);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    sb.push_back(7'd37);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      X = XW'(i * 7 + 3);
    end
    in_valid = 1'b0;
    wait_valid(seen, lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_R", 128'(R), 128'(37));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      in_valid = 1'b1;
      X = XW'(55);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_R_sb", 128'(R), 128'(sb.pop_front()));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 128'(out_valid), 128'(0));
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));

    // Reset at ACCUM cycle 7
    X = XW'(12345);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_accum_in_ready", 128'(in_ready), 128'(1));
    chk("rst_accum_out_valid", 128'(out_valid), 128'(0));
    chk("rst_accum_R", 128'(R), 128'(0));
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_accum_no_valid", 128'(seen), 128'(0));
    do_op(XW'(1000), 7'd37, -1, "after_rst");

    // Reset while DONE is stalled
    @(negedge clk);
    X = XW'(1000);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(seen, lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_done_out_valid", 128'(out_valid), 128'(0));
    chk("rst_done_in_ready", 128'(in_ready), 128'(1));
    chk("rst_done_R", 128'(R), 128'(0));
    out_ready = 1'b1;
    do_op(XW'(106), 7'd106, -1, "after_rst_done");

`ifdef XMOD_ABORT_EN
    // Abort in the first FOLD cycle
    do_op(XW'(1000), 7'd37, -1, "pre_abort");
    @(negedge clk);
    X = {XW{1'b1}};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NCH) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_R_held", 128'(R), 128'(37));
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 128'(seen), 128'(0));
    do_op({XW{1'b1}}, 7'd101, -1, "after_abort");
`endif

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
